// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, XAPP052 maximal-length tap table
// and length-mask helper for the LFSR engine.
package lfsr_pkg;

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode_e;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2
  } lfsr_state_e;

  // Tap i sets mask bit i-1; a zero argument means no tap.
  function automatic logic [63:0] tm(
    input int a, input int b, input int c, input int d
  );
    logic [63:0] m;
    m = '0;
    if (a > 0) m = m | (64'd1 << (a - 1));
    if (b > 0) m = m | (64'd1 << (b - 1));
    if (c > 0) m = m | (64'd1 << (c - 1));
    if (d > 0) m = m | (64'd1 << (d - 1));
    return m;
  endfunction

  localparam logic [63:0] TAP_TABLE [2:63] = '{
    tm( 2,  1,  0,  0), tm( 3,  2,  0,  0),
    tm( 4,  3,  0,  0), tm( 5,  3,  0,  0),
    tm( 6,  5,  0,  0), tm( 7,  6,  0,  0),
    tm( 8,  6,  5,  4), tm( 9,  5,  0,  0),
    tm(10,  7,  0,  0), tm(11,  9,  0,  0),
    tm(12,  6,  4,  1), tm(13,  4,  3,  1),
    tm(14,  5,  3,  1), tm(15, 14,  0,  0),
    tm(16, 15, 13,  4), tm(17, 14,  0,  0),
    tm(18, 11,  0,  0), tm(19,  6,  2,  1),
    tm(20, 17,  0,  0), tm(21, 19,  0,  0),
    tm(22, 21,  0,  0), tm(23, 18,  0,  0),
    tm(24, 23, 22, 17), tm(25, 22,  0,  0),
    tm(26,  6,  2,  1), tm(27,  5,  2,  1),
    tm(28, 25,  0,  0), tm(29, 27,  0,  0),
    tm(30,  6,  4,  1), tm(31, 28,  0,  0),
    tm(32, 22,  2,  1), tm(33, 20,  0,  0),
    tm(34, 27,  2,  1), tm(35, 33,  0,  0),
    tm(36, 25,  0,  0),
    tm(37,  5,  4,  3) | tm(2, 1, 0, 0),
    tm(38,  6,  5,  1), tm(39, 35,  0,  0),
    tm(40, 38, 21, 19), tm(41, 38,  0,  0),
    tm(42, 41, 20, 19), tm(43, 42, 38, 37),
    tm(44, 43, 18, 17), tm(45, 44, 42, 41),
    tm(46, 45, 26, 25), tm(47, 42,  0,  0),
    tm(48, 47, 21, 20), tm(49, 40,  0,  0),
    tm(50, 49, 24, 23), tm(51, 50, 36, 35),
    tm(52, 49,  0,  0), tm(53, 52, 38, 37),
    tm(54, 53, 18, 17), tm(55, 31,  0,  0),
    tm(56, 55, 35, 34), tm(57, 50,  0,  0),
    tm(58, 39,  0,  0), tm(59, 58, 38, 37),
    tm(60, 59,  0,  0), tm(61, 60, 46, 45),
    tm(62, 61,  6,  5), tm(63, 62,  0,  0)
  };

  function automatic logic [63:0] len_mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/lfsr_engine_mask_rom.sv
// lfsr_mask_rom: maps a register length to its tap mask
// and flags whether the length is supported.
module lfsr_mask_rom
  import lfsr_pkg::*;
#(
  parameter int MAX_LEN = 34,
  parameter int LEN_W   = 6
) (
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] mask,
  output logic               legal
);

  logic [5:0] idx;

  always_comb begin
    idx   = 6'(len);
    legal = (len >= LEN_W'(2)) &&
            (len <= LEN_W'(MAX_LEN));
    mask  = '0;
    if (legal) mask = MAX_LEN'(TAP_TABLE[idx]);
  end

endmodule

// File: rtl/lfsr_engine.sv
// lfsr_engine: runtime-configurable Fibonacci/Galois LFSR
// with seed load, step/run control and period measurement.
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int MAX_LEN = 34,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_mode,
  input  logic [MAX_LEN-1:0] cfg_seed,
  input  logic               run,
  input  logic               step,
  output logic [MAX_LEN-1:0] lfsr_value,
  output logic               lfsr_bit,
  output logic               value_valid,
  output logic               cfg_err,
  output logic               seed_fixed,
  output logic               period_pulse,
  output logic [MAX_LEN:0]   period_len
);

  localparam int CW = MAX_LEN + 1;

  lfsr_state_e        st_q, st_d;
  lfsr_mode_e         mode_q, mode_d;
  logic [MAX_LEN-1:0] val_q, val_d;
  logic [MAX_LEN-1:0] ref_q, ref_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] lmask_q, lmask_d;
  logic [MAX_LEN-1:0] topb_q, topb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      plen_q, plen_d;
  logic               err_q, err_d;
  logic               fix_q, fix_d;
  logic               pulse_q, pulse_d;

  logic [MAX_LEN-1:0] rom_mask;
  logic               rom_legal;
  logic [MAX_LEN-1:0] cfg_lmask;
  logic [MAX_LEN-1:0] seed_m;
  logic [MAX_LEN-1:0] fib_n, gal_n, nxt;
  logic [CW-1:0]      cnt_inc;
  logic               fb, msb, adv;

  lfsr_mask_rom #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_rom (
    .len  (cfg_len),
    .mask (rom_mask),
    .legal(rom_legal)
  );

  always_comb begin
    cfg_lmask = MAX_LEN'(len_mask(int'(cfg_len)));
    seed_m    = cfg_seed & cfg_lmask;
    fb        = ^(val_q & mask_q);
    msb       = |(val_q & topb_q);
    fib_n     = ((val_q << 1) | MAX_LEN'(fb)) & lmask_q;
    gal_n     = ((val_q << 1) ^
                 (msb ? ((mask_q << 1) | MAX_LEN'(1)) : '0))
                & lmask_q;
    nxt       = (mode_q == GALOIS) ? gal_n : fib_n;
    adv       = (st_q != UNCONF) && (run || step);
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    st_d    = st_q;
    mode_d  = mode_q;
    val_d   = val_q;
    ref_d   = ref_q;
    mask_d  = mask_q;
    lmask_d = lmask_q;
    topb_d  = topb_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    err_d   = err_q;
    fix_d   = fix_q;
    pulse_d = 1'b0;

    if (cfg_wr) begin
      cnt_d = '0;
      if (rom_legal) begin
        st_d    = HOLD;
        mode_d  = lfsr_mode_e'(cfg_mode);
        mask_d  = rom_mask;
        lmask_d = cfg_lmask;
        topb_d  = cfg_lmask ^ (cfg_lmask >> 1);
        err_d   = 1'b0;
        fix_d   = (seed_m == '0);
        val_d   = fix_d ? MAX_LEN'(1) : seed_m;
        ref_d   = val_d;
      end else begin
        st_d  = UNCONF;
        err_d = 1'b1;
        val_d = '0;
      end
    end else if (st_q != UNCONF && val_q == '0) begin
      // Lockup recovery behaves like a fresh load of 1.
      val_d = MAX_LEN'(1);
      ref_d = MAX_LEN'(1);
      fix_d = 1'b1;
      cnt_d = '0;
    end else if (adv) begin
      st_d  = run ? RUN : HOLD;
      val_d = nxt;
      if (nxt == ref_q) begin
        pulse_d = 1'b1;
        plen_d  = cnt_inc;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (st_q == RUN) begin
      st_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= UNCONF;
      mode_q  <= FIBONACCI;
      val_q   <= '0;
      ref_q   <= '0;
      mask_q  <= '0;
      lmask_q <= '0;
      topb_q  <= '0;
      cnt_q   <= '0;
      plen_q  <= '0;
      err_q   <= 1'b0;
      fix_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      ref_q   <= ref_d;
      mask_q  <= mask_d;
      lmask_q <= lmask_d;
      topb_q  <= topb_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      err_q   <= err_d;
      fix_q   <= fix_d;
      pulse_q <= pulse_d;
    end
  end

  assign lfsr_value   = val_q;
  assign lfsr_bit     = |(val_q & topb_q);
  assign value_valid  = (st_q != UNCONF) && (|val_q);
  assign cfg_err      = err_q;
  assign seed_fixed   = fix_q;
  assign period_pulse = pulse_q;
  assign period_len   = plen_q;

endmodule

// File: doc/lfsr_engine.md
# lfsr_engine

Parametrised, runtime-configurable maximal-length LFSR for the pattern-generation path. It generalises the fixed-mask Fibonacci register to any length from 2 to MAX_LEN, in either Fibonacci or Galois mode. It adds a seed-load handshake, single-step and free-run control, zero-state protection and on-line period measurement. It sits between the host configuration registers and the pattern/compare datapath.

## Interface
Parameters:
- MAX_LEN, 34: widest supported register; legal 2..63.
- LEN_W, 6: width of the length field; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_wr  in  1  one-cycle strobe; loads cfg_len, cfg_mode and cfg_seed.
- cfg_len  in  LEN_W  register length n.
- cfg_mode  in  1  feedback structure: 0 = Fibonacci, 1 = Galois.
- cfg_seed  in  MAX_LEN  initial state; only bits [n-1:0] are used.
- run  in  1  level input; advances one step per cycle while high.
- step  in  1  one-cycle strobe; advances exactly one step.
- lfsr_value  out  MAX_LEN  current state, zero-extended above bit n-1.
- lfsr_bit  out  1  lfsr_value[n-1] (the serial output).
- value_valid  out  1  high when the engine is configured and the state is non-zero.
- cfg_err  out  1  sticky; set when cfg_len < 2 or cfg_len > MAX_LEN.
- seed_fixed  out  1  sticky; set when a zero seed was replaced.
- period_pulse  out  1  one-cycle pulse when the state returns to the loaded seed.
- period_len  out  MAX_LEN+1  step count of the last completed period.

## Operation
- The tap mask for each length comes from the shared XAPP052 maximal-length table. Bit i-1 of the mask is set for tap i.
- Fibonacci step: next = {s[n-2:0], ^(s & mask)}.
- Galois step: next = s[n-1] ? ({s[n-2:0],1'b0} ^ (mask << 1) ^ 1) : {s[n-2:0],1'b0}, truncated to n bits.
- All arithmetic is on bits [n-1:0]; bits [MAX_LEN-1:n] are held at 0.
- States:
  - UNCONF (after reset): no advance; value_valid = 0.
  - Any cfg_wr with a legal length goes to HOLD.
  - A cfg_wr with an illegal length goes to UNCONF, sets cfg_err and zeroes lfsr_value.
  - HOLD: advances one step on step; goes to RUN while run = 1.
  - RUN: advances every cycle; returns to HOLD when run = 0. While in RUN, step has no extra effect.
- Seed load: if (cfg_seed & len_mask) == 0, the engine loads 1 instead and sets seed_fixed. Otherwise it loads the masked seed. The loaded value is stored as ref_seed.
- Period counter:
  - It counts advances since the last load or the last period_pulse.
  - When an advance produces ref_seed, the engine asserts period_pulse, writes count+1 to period_len and clears the counter.
  - The counter saturates at all-ones and never wraps.
- cfg_err and seed_fixed clear only on rst or on a subsequent legal cfg_wr.

## Timing
- Reset values: lfsr_value 0, lfsr_bit 0, value_valid 0, cfg_err 0, seed_fixed 0, period_pulse 0, period_len 0; state UNCONF.
- cfg_wr sampled at edge k: the loaded seed appears on lfsr_value after edge k. value_valid rises in the same cycle.
- Advance latency: run or step sampled at edge k means the next state is visible after edge k.
- period_pulse is asserted in the same cycle as the state equal to ref_seed.
- Priority: rst > cfg_wr > run/step. A cfg_wr together with step loads the seed and does not advance.
- If cfg_len changes without cfg_wr, it has no effect; configuration is latched.
- Reset mid-run: all outputs take their reset values at the next edge. The period counter is discarded.
- Lockup: the zero state is unreachable from a non-zero seed. If a zero state is ever detected, the engine reloads 1 and sets seed_fixed.

## Structure
- Package lfsr_pkg holds:
  - the mode enum (FIBONACCI, GALOIS);
  - the FSM state enum (UNCONF, HOLD, RUN);
  - the tap table as a constant array indexed by length, 2..63;
  - the function len_mask(n).
- Sub-module lfsr_mask_rom: combinational; maps cfg_len to mask and legal. It is instantiated once and registered at cfg_wr.
- The top level contains the FSM, the state register, the period counter and the sticky flags.

## Test plan
- Fibonacci, n=4, mask 4'b1100, seed 4'b0001, step ×3 -> lfsr_value reads 0010, 0100, then 1001.
- Same config, run held for 15 cycles -> period_pulse exactly on the 15th advance; period_len = 15; the 15 states are distinct and non-zero.
- Galois, n=16, seed 16'hACE1, run 65535 cycles -> period_len = 65535; period_pulse fires once.
- cfg_wr with seed 0 (n=8) -> lfsr_value = 1; seed_fixed = 1; value_valid = 1. cfg_wr with cfg_len=1 -> cfg_err = 1; value_valid = 0; step is ignored.
- cfg_wr together with step at n=5, seed 5'h13 -> lfsr_value = 5'h13 with no advance. rst asserted mid-RUN -> all outputs zero next cycle, state UNCONF.
